// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port-B arbiter.
// Optional feature macro used by the arbiter files: RAM_ARB_LOCK_EN.
package ram_arb_pkg;

  localparam int unsigned RAM_ARB_DATA_W = 16;
  localparam int unsigned RAM_ARB_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker holding the last_winner register.
// With RAM_ARB_LOCK_EN defined, a lock captured during ISSUE makes the
// previous winner win the next arbitration if it is requesting.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,          // bit 0 = CPU, bit 1 = EXT
  input  logic       update,       // accept the current pick
`ifdef RAM_ARB_LOCK_EN
  input  logic       lock_capture, // high during ISSUE
  input  logic       lock_in,      // current winner's lock
`endif
  output logic       valid,
  output req_id_e    winner,
  output req_id_e    last_winner
);

  req_id_e last_q;
`ifdef RAM_ARB_LOCK_EN
  logic    lock_q;
  logic    locked_req;
`endif

  assign last_winner = last_q;

  // Pick: lone requester wins; on a tie the one that did not win last time.
  always_comb begin
    valid  = |req;
    winner = REQ_CPU;
    if (req[0] && req[1]) begin
      winner = (last_q == REQ_CPU) ? REQ_EXT : REQ_CPU;
    end else if (req[1]) begin
      winner = REQ_EXT;
    end
`ifdef RAM_ARB_LOCK_EN
    locked_req = (last_q == REQ_CPU) ? req[0] : req[1];
    if (lock_q && locked_req) begin
      winner = last_q;
    end
`endif
  end

  // last_winner register; reset to EXT so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_EXT;
    end else if (update) begin
      last_q <= winner;
    end
  end

`ifdef RAM_ARB_LOCK_EN
  // Lock state sampled from the winner during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (lock_capture) begin
      lock_q <= lock_in;
    end
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port B between the CPU load/store path and an external master.
// Each access is one req/gnt word transaction; all outputs are registered.
// Optional feature: define RAM_ARB_LOCK_EN to add cpu_lock/ext_lock.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = RAM_ARB_DATA_W,
  parameter int unsigned ADDR_W = RAM_ARB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic              cpu_lock,
  input  logic              ext_lock,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_we_q, ram_we_d;
  logic              cpu_gnt_q, cpu_gnt_d, ext_gnt_q, ext_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ext_rdata_q, ext_rdata_d;
  logic              busy_q, busy_d;

  logic              arb_valid;
  logic              arb_update;
  req_id_e           arb_winner;
  req_id_e           last_winner;

  rr_arbiter2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          ({ext_req, cpu_req}),
    .update       (arb_update),
`ifdef RAM_ARB_LOCK_EN
    .lock_capture (state_q == ISSUE),
    .lock_in      ((last_winner == REQ_CPU) ? cpu_lock : ext_lock),
`endif
    .valid        (arb_valid),
    .winner       (arb_winner),
    .last_winner  (last_winner)
  );

  // Next-state and registered-output values; last_winner names the owner
  // of the transaction in flight.
  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_we_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    ext_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    ext_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    arb_update   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          state_d    = ISSUE;
          if (arb_winner == REQ_CPU) begin
            ram_addr_d = cpu_addr;
            ram_data_d = cpu_wdata;
            ram_we_d   = cpu_we;
            cpu_gnt_d  = 1'b1;
          end else begin
            ram_addr_d = ext_addr;
            ram_data_d = ext_wdata;
            ram_we_d   = ext_we;
            ext_gnt_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = ram_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        state_d = IDLE;
        if (last_winner == REQ_CPU) begin
          cpu_rdata_d  = ram_q;
          cpu_rvalid_d = 1'b1;
        end else begin
          ext_rdata_d  = ram_q;
          ext_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_we_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_we_q     <= ram_we_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ext_gnt_q    <= ext_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_we     = ram_we_q;
  assign cpu_gnt    = cpu_gnt_q;
  assign ext_gnt    = ext_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ext_rdata  = ext_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAM on port B.
// Stimulus pushes expected grant/rvalid events; a negedge monitor checks them.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [9:0]  ext_addr = '0;
  logic [15:0] ext_wdata = '0;
  logic        ext_gnt, ext_rvalid;
  logic [15:0] ext_rdata;
`ifdef RAM_ARB_LOCK_EN
  logic        cpu_lock = 1'b0, ext_lock = 1'b0;
`endif
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic [15:0] ram_q;
  logic        busy;

  ram_port_arbiter #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
`ifdef RAM_ARB_LOCK_EN
    .cpu_lock   (cpu_lock),
    .ext_lock   (ext_lock),
`endif
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .ram_q      (ram_q),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port B model: synchronous write, registered read.
  logic [15:0] mem [0:1023];
  bit preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[10'h3FF] <= 16'h1234;
      mem[10'h010] <= 16'h0110;
      preloaded    <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    int          cyc;
    bit          is_rv;
    bit          port;   // 0 = CPU, 1 = EXT
    bit          we;
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(int c, bit rv, bit port, bit we, logic [9:0] addr,
                               logic [15:0] data);
    exp_t e;
    e.cyc = c; e.is_rv = rv; e.port = port; e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: one event per cycle at most; each is matched against the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    int   nev;
    bit   obs_rv, obs_port;
    nev = 0;
    if (cpu_gnt) nev++;
    if (ext_gnt) nev++;
    if (cpu_rvalid) nev++;
    if (ext_rvalid) nev++;
    obs_rv   = cpu_rvalid | ext_rvalid;
    obs_port = ext_gnt | ext_rvalid;
    if (ram_we) check("ram_we_only_with_gnt", 32'(cpu_gnt | ext_gnt), 32'd1);
    if (nev > 1) begin
      check("events_per_cycle", 32'(nev), 32'd1);
    end else if (nev == 1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, obs_rv, obs_port}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_kind", 32'(obs_rv), 32'(e.is_rv));
        check("event_port", 32'(obs_port), 32'(e.port));
        if (!obs_rv) begin
          check("gnt_ram_we", 32'(ram_we), 32'(e.we));
          check("gnt_ram_addr", 32'(ram_addr), 32'(e.addr));
          if (e.we) check("gnt_ram_data", 32'(ram_data), 32'(e.data));
          check("gnt_busy", 32'(busy), 32'd1);
        end else begin
          check("rdata", 32'(obs_port ? ext_rdata : cpu_rdata), 32'(e.data));
        end
      end
    end
  end

  task automatic set_port(input bit port, input bit req, input bit we, input logic [9:0] addr,
                          input logic [15:0] d);
    if (!port) begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = d;
    end else begin
      ext_req = req; ext_we = we; ext_addr = addr; ext_wdata = d;
    end
  endtask

  // Called at posedge+1; returns in the first IDLE cycle (bounded).
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // One transaction from a lone requester; req dropped on the grant cycle.
  task automatic single(input bit port, input bit we, input logic [9:0] addr,
                        input logic [15:0] d, input logic [15:0] exp_rd);
    wait_idle();
    set_port(port, 1'b1, we, addr, d);
    push(cyc + 1, 1'b0, port, we, addr, d);
    if (!we) push(cyc + 3, 1'b1, port, 1'b0, addr, exp_rd);
    @(posedge clk); #1;
    set_port(port, 1'b0, we, addr, d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'd0);
    check({tag, "_ext_gnt"}, 32'(ext_gnt), 32'd0);
    check({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    check({tag, "_ext_rvalid"}, 32'(ext_rvalid), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_ext_rdata"}, 32'(ext_rdata), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c;
    #3;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesting from reset: grants alternate C,E,C,E,C,E every 2 cycles.
    c = cyc;
    set_port(1'b0, 1'b1, 1'b1, 10'h020, 16'hC000);
    set_port(1'b1, 1'b1, 1'b1, 10'h021, 16'hE000);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(c + 1 + 2 * k, 1'b0, 1'b0, 1'b1, 10'h020, 16'hC000);
      else            push(c + 1 + 2 * k, 1'b0, 1'b1, 1'b1, 10'h021, 16'hE000);
    end
    repeat (11) begin @(posedge clk); #1; end
    cpu_req = 1'b0;
    ext_req = 1'b0;

    // CPU write then read-back of the same word.
    single(1'b0, 1'b1, 10'h005, 16'hBEEF, 16'h0000);
    single(1'b0, 1'b0, 10'h005, 16'h0000, 16'hBEEF);

    // EXT read of the top address; CPU stays quiet.
    single(1'b1, 1'b0, 10'h3FF, 16'h0000, 16'h1234);

    // CPU pulses req only while EXT is in ISSUE: never granted.
    wait_idle();
    c = cyc;
    set_port(1'b1, 1'b1, 1'b1, 10'h030, 16'h5555);
    push(c + 1, 1'b0, 1'b1, 1'b1, 10'h030, 16'h5555);
    @(posedge clk); #1;
    ext_req = 1'b0;
    set_port(1'b0, 1'b1, 1'b1, 10'h031, 16'h9999);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Reset during RDWAIT: grant seen, read data dropped.
    wait_idle();
    c = cyc;
    set_port(1'b0, 1'b1, 1'b0, 10'h020, 16'h0000);
    push(c + 1, 1'b0, 1'b0, 1'b0, 10'h020, 16'h0000);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midread");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    single(1'b0, 1'b0, 10'h005, 16'h0000, 16'hBEEF);

`ifdef RAM_ARB_LOCK_EN
    // Locked CPU read of 0x10 makes the CPU win the following tie.
    single(1'b1, 1'b1, 10'h011, 16'h7777, 16'h0000);
    wait_idle();
    c = cyc;
    set_port(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000);
    cpu_lock = 1'b1;
    set_port(1'b1, 1'b1, 1'b1, 10'h011, 16'h2222);
    push(c + 1, 1'b0, 1'b0, 1'b0, 10'h010, 16'h0000);
    push(c + 3, 1'b1, 1'b0, 1'b0, 10'h010, 16'h0110);
    push(c + 4, 1'b0, 1'b0, 1'b1, 10'h010, 16'hAAAA);
    push(c + 6, 1'b0, 1'b1, 1'b1, 10'h011, 16'h2222);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b1, 10'h010, 16'hAAAA);
    @(posedge clk); #1;
    cpu_lock = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    cpu_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ext_req = 1'b0;
    single(1'b0, 1'b0, 10'h010, 16'h0000, 16'hAAAA);
`endif

    repeat (6) begin @(posedge clk); #1; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the data port (port B) of the dual-port program/data RAM between two requesters: the CPU load/store path (CPU) and an external memory-mapped master (EXT), e.g. an I/O or display fetch engine.
- Sequences each access as a single-word req/gnt transaction, drives the RAM port signals from registers, and returns read data with a one-cycle valid pulse.
- Sits between the CPU datapath and the RAM; port A (instruction fetch) is untouched.

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 10, RAM word-address width.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous reset, active-low.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  one-cycle grant pulse.
- cpu_rvalid  out  1  one-cycle read-data-valid pulse.
- cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid.
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata: same as the cpu_* ports, for EXT.
- ram_addr  out  ADDR_W  to RAM port B address.
- ram_data  out  DATA_W  to RAM port B write data.
- ram_we  out  1  to RAM port B write enable.
- ram_q  in  DATA_W  RAM port B registered read output; valid 1 cycle after address is sampled.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (Rst=0, asynchronous):
  - All outputs 0; state IDLE.
  - last_winner = EXT, so CPU wins the first tie.
  - Any in-flight read is dropped with no rvalid. Outputs stay 0 until Rst is released and a new request arrives.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one requester has req=1, it wins.
  - If both request, the requester that is not last_winner wins.
  - On a win, register the winner's addr/we/wdata into ram_addr/ram_we/ram_data, set that requester's gnt, update last_winner, and go to ISSUE.
- ISSUE (1 cycle):
  - gnt is high for exactly this cycle; ram_we equals the winner's we.
  - RAM samples the port at the end of this cycle.
  - Next state is RDWAIT for a read, IDLE for a write.
  - ram_we clears to 0 on leaving ISSUE.
- RDWAIT (1 cycle):
  - ram_q is valid; capture it into the winner's rdata.
  - The winner's rvalid pulses high in the following cycle; go to IDLE.
- Latency from req first seen in IDLE (cycle N):
  - gnt in cycle N+1.
  - Write committed at the edge ending N+1.
  - Read: rvalid and rdata in cycle N+3.
- Back-to-back requests:
  - A request held through the previous transaction is arbitrated in the first IDLE cycle.
  - Minimum spacing: 2 cycles per write, 3 per read.
- Requesters:
  - Must hold req and fields stable until gnt.
  - May drop req only before gnt; the arbiter samples req only in IDLE.
  - A req held after gnt is treated as a new request.
- Outside ISSUE, ram_we=0. ram_addr and ram_data hold their last values.
- rdata holds its last value after rvalid; the loser's gnt, rvalid and rdata are unchanged.
- A write and a read to the same address in consecutive transactions: the read returns the new data.
- Arbitration is strictly fair: under continuous requests from both, grants alternate CPU, EXT, CPU, ...

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- With the macro defined:
  - Adds inputs cpu_lock and ext_lock (1 bit each).
  - If the winner's lock is high during ISSUE, the next IDLE arbitration grants the same requester when it is requesting, overriding round-robin. This supports atomic read-modify-write.
  - Lock is ignored if the locked requester is not requesting in that IDLE cycle.
  - Reset clears the lock state.
- Without the macro: the lock ports are absent and arbitration is pure round-robin.

Decomposition:
- Package ram_arb_pkg:
  - State enum (IDLE, ISSUE, RDWAIT).
  - Requester ID enum (REQ_CPU=0, REQ_EXT=1).
  - Default DATA_W and ADDR_W constants.
- Sub-module rr_arbiter2: 2-way round-robin pick plus last_winner register (and lock override when RAM_ARB_LOCK_EN is defined). The top module holds the FSM and the port registers.

Test Plan:
- Reset mid-read: assert Rst=0 in RDWAIT -> no rvalid, all outputs 0, busy=0; after release, the next request is granted normally.
- CPU write then read: write addr 0x05 data 0xBEEF -> cpu_gnt at N+1, ram_we=1 for exactly 1 cycle; read addr 0x05 -> cpu_rvalid at N+3 with cpu_rdata=0xBEEF.
- Simultaneous first requests after reset: both req -> cpu_gnt first, then ext_gnt; held for 6 transactions -> grants alternate C,E,C,E,C,E.
- EXT read while CPU idle: ext_addr=0x3FF preloaded 0x1234 -> ext_rvalid at N+3, ext_rdata=0x1234; cpu_rvalid stays 0 throughout.
- Withdrawn request: cpu_req pulses 1 cycle while state=ISSUE(EXT) -> never granted, ram_we never asserted for the CPU.
- With RAM_ARB_LOCK_EN: cpu_lock=1 on a read of 0x10, both requesting -> next grant is CPU (write 0x10), then EXT.
